eve_gene_aligner: RTL

//  Front-end for the EvE crossover array. Merges two key-sorted parent gene streams into aligned gene pairs.

---
 rtl/eve_gene_aligner.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/eve_gene_aligner.sv
// EvE crossover front-end: merges two key-sorted parent gene streams into aligned,
// classified gene pairs and dispatches them round-robin to NUM_PE lanes.

module eve_gene_aligner_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

module eve_gene_aligner #(
  parameter int NUM_PE     = 8,
  parameter int GENE_W     = 64,
  parameter int KEY_LSB    = 40,
  parameter int KEY_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              input_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [GENE_W-1:0] a_gene,
  input  logic              a_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [GENE_W-1:0] b_gene,
  input  logic              b_last,
  output logic [NUM_PE-1:0] out_valid,
  input  logic [NUM_PE-1:0] out_ready,
  output logic [GENE_W-1:0] out_gene_a,
  output logic [GENE_W-1:0] out_gene_b,
  output logic [1:0]        out_kind,
  output logic [1:0]        out_src,
  output logic              done,
  output logic              err_order,
  output logic [15:0]       cnt_match,
  output logic [15:0]       cnt_disj,
  output logic [15:0]       cnt_exc
);
  localparam int LANE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MERGE   = 3'd1;
  localparam logic [2:0] S_DRAIN_A = 3'd2;
  localparam logic [2:0] S_DRAIN_B = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] KIND_MATCH = 2'b01;
  localparam logic [1:0] KIND_DISJ  = 2'b10;
  localparam logic [1:0] KIND_EXC   = 2'b11;

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [LANE_W-1:0] lane;
  logic              out_full;

  logic [GENE_W:0]   a_head_raw;
  logic [GENE_W:0]   b_head_raw;
  logic              a_empty;
  logic              b_empty;
  logic              a_full;
  logic              b_full;
  logic [GENE_W-1:0] a_head;
  logic [GENE_W-1:0] b_head;
  logic              a_head_last;
  logic              b_head_last;
  logic [KEY_W-1:0]  key_a;
  logic [KEY_W-1:0]  key_b;

  logic              accept;
  logic              slot_free;
  logic              start_go;
  logic              issue;
  logic              pop_a;
  logic              pop_b;
  logic [GENE_W-1:0] iss_a;
  logic [GENE_W-1:0] iss_b;
  logic [1:0]        iss_kind;
  logic [1:0]        iss_src;

  logic [KEY_W-1:0]  a_prev;
  logic [KEY_W-1:0]  b_prev;
  logic              a_seen;
  logic              b_seen;

  eve_gene_aligner_fifo #(.W(GENE_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk   (input_clk),
    .rst   (reset),
    .push  (a_valid),
    .din   ({a_last, a_gene}),
    .pop   (pop_a),
    .dout  (a_head_raw),
    .empty (a_empty),
    .full  (a_full)
  );

  eve_gene_aligner_fifo #(.W(GENE_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk   (input_clk),
    .rst   (reset),
    .push  (b_valid),
    .din   ({b_last, b_gene}),
    .pop   (pop_b),
    .dout  (b_head_raw),
    .empty (b_empty),
    .full  (b_full)
  );

  assign a_ready     = !a_full;
  assign b_ready     = !b_full;
  assign a_head      = a_head_raw[GENE_W-1:0];
  assign b_head      = b_head_raw[GENE_W-1:0];
  assign a_head_last = a_head_raw[GENE_W];
  assign b_head_last = b_head_raw[GENE_W];
  assign key_a       = a_head[KEY_LSB +: KEY_W];
  assign key_b       = b_head[KEY_LSB +: KEY_W];

  // Only the currently selected lane's ready matters; a pair issues into the slot it frees.
  assign accept    = out_full && out_ready[lane];
  assign slot_free = !out_full || accept;
  assign start_go  = (state == S_IDLE) && start;
  assign done      = (state == S_DONE);

  always_comb begin
    out_valid = '0;
    if (out_full) out_valid[lane] = 1'b1;
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    pop_a      = 1'b0;
    pop_b      = 1'b0;
    iss_a      = '0;
    iss_b      = '0;
    iss_kind   = '0;
    iss_src    = '0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_MERGE;
      end
      S_MERGE: begin
        if (!a_empty && !b_empty && slot_free) begin
          issue = 1'b1;
          if (key_a == key_b) begin
            pop_a    = 1'b1;
            pop_b    = 1'b1;
            iss_a    = a_head;
            iss_b    = b_head;
            iss_kind = KIND_MATCH;
            iss_src  = 2'b11;
          end else if (key_a < key_b) begin
            pop_a    = 1'b1;
            iss_a    = a_head;
            iss_kind = KIND_DISJ;
            iss_src  = 2'b01;
          end else begin
            pop_b    = 1'b1;
            iss_b    = b_head;
            iss_kind = KIND_DISJ;
            iss_src  = 2'b10;
          end
          // Whichever parent runs out first leaves the other to drain as excess.
          if (pop_a && a_head_last && pop_b && b_head_last) next_state = S_DONE;
          else if (pop_a && a_head_last)                    next_state = S_DRAIN_B;
          else if (pop_b && b_head_last)                    next_state = S_DRAIN_A;
        end
      end
      S_DRAIN_A: begin
        if (!a_empty && slot_free) begin
          issue    = 1'b1;
          pop_a    = 1'b1;
          iss_a    = a_head;
          iss_kind = KIND_EXC;
          iss_src  = 2'b01;
          if (a_head_last) next_state = S_DONE;
        end
      end
      S_DRAIN_B: begin
        if (!b_empty && slot_free) begin
          issue    = 1'b1;
          pop_b    = 1'b1;
          iss_b    = b_head;
          iss_kind = KIND_EXC;
          iss_src  = 2'b10;
          if (b_head_last) next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      lane       <= '0;
      out_full   <= 1'b0;
      out_gene_a <= '0;
      out_gene_b <= '0;
      out_kind   <= '0;
      out_src    <= '0;
      cnt_match  <= '0;
      cnt_disj   <= '0;
      cnt_exc    <= '0;
      err_order  <= 1'b0;
      a_prev     <= '0;
      b_prev     <= '0;
      a_seen     <= 1'b0;
      b_seen     <= 1'b0;
    end else begin
      state <= next_state;

      if (issue) begin
        out_full   <= 1'b1;
        out_gene_a <= iss_a;
        out_gene_b <= iss_b;
        out_kind   <= iss_kind;
        out_src    <= iss_src;
      end else if (accept) begin
        out_full <= 1'b0;
      end

      if (accept) lane <= (lane == LANE_W'(NUM_PE - 1)) ? '0 : lane + LANE_W'(1);

      if (start_go) begin
        cnt_match <= '0;
        cnt_disj  <= '0;
        cnt_exc   <= '0;
        err_order <= 1'b0;
        a_prev    <= '0;
        b_prev    <= '0;
        a_seen    <= 1'b0;
        b_seen    <= 1'b0;
      end else begin
        if (issue) begin
          case (iss_kind)
            KIND_MATCH: if (cnt_match != 16'hFFFF) cnt_match <= cnt_match + 16'd1;
            KIND_DISJ:  if (cnt_disj  != 16'hFFFF) cnt_disj  <= cnt_disj  + 16'd1;
            KIND_EXC:   if (cnt_exc   != 16'hFFFF) cnt_exc   <= cnt_exc   + 16'd1;
            default: ;
          endcase
        end
        // The first pop of a genome has nothing to compare against, hence the seen flags.
        if (pop_a) begin
          if (a_seen && key_a <= a_prev) err_order <= 1'b1;
          a_prev <= key_a;
          a_seen <= 1'b1;
        end
        if (pop_b) begin
          if (b_seen && key_b <= b_prev) err_order <= 1'b1;
          b_prev <= key_b;
          b_seen <= 1'b1;
        end
      end
    end
  end
endmodule
